// File: rtl/mult_vector_bank_multi_pkg.sv
// Shared types and defaults for the multiply-result vector bank.
package mvb_pkg;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_STREAM,
        DR_DONE
    } drain_state_t;

    localparam int unsigned MVB_WIDTH = 32;
    localparam int unsigned MVB_LANES = 4;
    localparam int unsigned MVB_SLOTS = 2;

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_vector_bank_multi_if.sv
// Write, read-back and drain signals of the vector bank, seen from the bank (slave) or its user (master).
interface mult_vector_bank_multi_if
    import mvb_pkg::*;
#(
    parameter int unsigned WIDTH = MVB_WIDTH,
    parameter int unsigned LANES = MVB_LANES,
    parameter int unsigned SLOTS = MVB_SLOTS
) ();

    localparam int unsigned SW = idx_w(SLOTS);

    logic                         we;
    logic                         wr_auto;
    logic [SW-1:0]                wr_slot;
    logic [LANES*WIDTH-1:0]       wd;
    logic                         clr;
    logic [SLOTS*LANES*WIDTH-1:0] rd_flat;
    logic [SLOTS-1:0]             slot_valid;
    logic                         full;
    logic                         wr_err;
    logic                         drain_start;
    logic [SW-1:0]                drain_slot;
    logic [WIDTH-1:0]             drain_data;
    logic                         drain_valid;
    logic                         drain_ready;
    logic                         drain_busy;
    logic                         drain_done;

    modport slave (
        input  we, wr_auto, wr_slot, wd, clr, drain_start, drain_slot, drain_ready,
        output rd_flat, slot_valid, full, wr_err, drain_data, drain_valid, drain_busy, drain_done
    );

    modport master (
        output we, wr_auto, wr_slot, wd, clr, drain_start, drain_slot, drain_ready,
        input  rd_flat, slot_valid, full, wr_err, drain_data, drain_valid, drain_busy, drain_done
    );

endinterface

// File: rtl/mult_vector_bank_multi_drain_fsm.sv
// Lane-serial drain: snapshots one slot, streams it one lane per accepted beat, then
// asks the bank to retire that slot.
module mvb_drain_fsm
    import mvb_pkg::*;
#(
    parameter  int unsigned WIDTH = MVB_WIDTH,
    parameter  int unsigned LANES = MVB_LANES,
    parameter  int unsigned SLOTS = MVB_SLOTS,
    localparam int unsigned SW    = idx_w(SLOTS),
    localparam int unsigned LW    = idx_w(LANES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [SW-1:0]                slot,
    input  logic [SLOTS-1:0]             slot_valid,
    input  logic [SLOTS*LANES*WIDTH-1:0] rd_flat,
    input  logic                         ready,
    output logic [WIDTH-1:0]             data,
    output logic                         valid,
    output logic                         busy,
    output logic                         done,
    output logic                         start_err,
    output logic                         clr_slot_valid,
    output logic [SW-1:0]                clr_idx
);

    drain_state_t     state_q, state_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [SW-1:0]    slot_q, slot_d;
    logic [WIDTH-1:0] snap_q [LANES];
    logic [WIDTH-1:0] snap_d [LANES];

    always_comb begin
        state_d        = state_q;
        lane_d         = lane_q;
        slot_d         = slot_q;
        snap_d         = snap_q;
        valid          = 1'b0;
        done           = 1'b0;
        start_err      = 1'b0;
        clr_slot_valid = 1'b0;
        case (state_q)
            DR_IDLE: begin
                if (start) begin
                    if (slot_valid[slot]) begin
                        for (int unsigned l = 0; l < LANES; l++) begin
                            snap_d[l] = rd_flat[(32'(slot) * LANES + l) * WIDTH +: WIDTH];
                        end
                        lane_d  = '0;
                        slot_d  = slot;
                        state_d = DR_STREAM;
                    end else begin
                        start_err = 1'b1;
                    end
                end
            end
            DR_STREAM: begin
                valid = 1'b1;
                if (ready) begin
                    if (lane_q == LW'(LANES - 1)) begin
                        state_d = DR_DONE;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            DR_DONE: begin
                done           = 1'b1;
                clr_slot_valid = 1'b1;
                state_d        = DR_IDLE;
            end
            default: state_d = DR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DR_IDLE;
            lane_q  <= '0;
            slot_q  <= '0;
            for (int unsigned l = 0; l < LANES; l++) begin
                snap_q[l] <= '0;
            end
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            slot_q  <= slot_d;
            snap_q  <= snap_d;
        end
    end

    assign data    = snap_q[lane_q];
    assign busy    = (state_q != DR_IDLE);
    assign clr_idx = slot_q;

endmodule

// File: rtl/mult_vector_bank_multi.sv
// Multiply-result vector bank: SLOTS x LANES x WIDTH storage with explicit/auto writes,
// per-slot valid tracking, error pulse and a lane-serial drain port.
module mult_vector_bank_multi
    import mvb_pkg::*;
#(
    parameter  int unsigned WIDTH = MVB_WIDTH,
    parameter  int unsigned LANES = MVB_LANES,
    parameter  int unsigned SLOTS = MVB_SLOTS,
    localparam int unsigned SW    = idx_w(SLOTS)
) (
    input logic                      clk,
    input logic                      rst,
    mult_vector_bank_multi_if.slave  bus
);

    logic [WIDTH-1:0] mem_q [SLOTS][LANES];
    logic [WIDTH-1:0] mem_d [SLOTS][LANES];
    logic [SLOTS-1:0] valid_q, valid_d;
    logic [SW-1:0]    wr_ptr_q, wr_ptr_d;
    logic             wr_err_q, wr_err_d;
    logic             rewritten_q, rewritten_d;

    logic             drain_err;
    logic             drain_clr;
    logic [SW-1:0]    drain_idx;
    logic [SW-1:0]    tgt;
    logic             do_write;
    logic             auto_full;

    mvb_drain_fsm #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .SLOTS (SLOTS)
    ) u_drain (
        .clk            (clk),
        .rst            (rst),
        .start          (bus.drain_start),
        .slot           (bus.drain_slot),
        .slot_valid     (valid_q),
        .rd_flat        (bus.rd_flat),
        .ready          (bus.drain_ready),
        .data           (bus.drain_data),
        .valid          (bus.drain_valid),
        .busy           (bus.drain_busy),
        .done           (bus.drain_done),
        .start_err      (drain_err),
        .clr_slot_valid (drain_clr),
        .clr_idx        (drain_idx)
    );

    always_comb begin
        mem_d     = mem_q;
        valid_d   = valid_q;
        wr_ptr_d  = wr_ptr_q;
        wr_err_d  = drain_err;
        tgt       = bus.wr_slot;
        do_write  = 1'b0;
        auto_full = !bus.clr && (&valid_q);

        if (bus.clr) begin
            valid_d  = '0;
            wr_ptr_d = '0;
        end
        // A slot rewritten after its snapshot holds a fresh result, so retiring it is skipped.
        if (drain_clr && !rewritten_q) begin
            valid_d[drain_idx] = 1'b0;
        end

        if (bus.we) begin
            if (bus.wr_auto) begin
                if (auto_full) begin
                    wr_err_d = 1'b1;
                end else begin
                    tgt      = bus.clr ? '0 : wr_ptr_q;
                    do_write = 1'b1;
                    wr_ptr_d = (tgt == SW'(SLOTS - 1)) ? '0 : tgt + 1'b1;
                end
            end else begin
                tgt      = bus.wr_slot;
                do_write = 1'b1;
            end
        end

        if (do_write) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                mem_d[tgt][l] = bus.wd[l * WIDTH +: WIDTH];
            end
            valid_d[tgt] = 1'b1;
        end

        // Outside a drain the flag tracks the start-cycle write, so it is correct once a start is taken.
        if (bus.drain_busy) begin
            rewritten_d = rewritten_q || (do_write && (tgt == drain_idx));
        end else begin
            rewritten_d = do_write && (tgt == bus.drain_slot);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned s = 0; s < SLOTS; s++) begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    mem_q[s][l] <= '0;
                end
            end
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            wr_err_q    <= 1'b0;
            rewritten_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_err_q    <= wr_err_d;
            rewritten_q <= rewritten_d;
        end
    end

    always_comb begin
        bus.rd_flat = '0;
        for (int unsigned s = 0; s < SLOTS; s++) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                bus.rd_flat[(s * LANES + l) * WIDTH +: WIDTH] = mem_q[s][l];
            end
        end
    end

    assign bus.slot_valid = valid_q;
    assign bus.full       = &valid_q;
    assign bus.wr_err     = wr_err_q;

endmodule

// File: tb/tb_mult_vector_bank_multi.sv
// Bench for mult_vector_bank_multi: directed scenarios with literal expectations, then
// random traffic, all tracked every cycle by a queue-based reference model.
module tb_mult_vector_bank_multi;

    localparam int unsigned W = 32;
    localparam int unsigned L = 4;
    localparam int unsigned S = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mult_vector_bank_multi_if #(.WIDTH(W), .LANES(L), .SLOTS(S)) bus ();

    mult_vector_bank_multi #(.WIDTH(W), .LANES(L), .SLOTS(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [S*L*W-1:0] act, input logic [S*L*W-1:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0]     m_mem [S][L];
    logic [S-1:0]     m_valid;
    int               m_ptr;
    bit               m_err;
    bit               m_done;
    bit               m_dirty;
    int               m_dslot;
    logic [W-1:0]     m_q[$];
    bit               live = 1'b0;

    logic [S-1:0]     nv;
    int               np, t;
    bit               ne, nd, wr;
    logic [S*L*W-1:0] exp_flat;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            for (int s = 0; s < S; s++)
                for (int l = 0; l < L; l++) m_mem[s][l] = '0;
            m_valid = '0; m_ptr = 0; m_err = 0; m_done = 0; m_dirty = 0; m_dslot = 0;
            m_q.delete();
            live = 1'b1;
        end else if (live) begin
            nv = m_valid; np = m_ptr; ne = 0; nd = 0; wr = 0; t = 0;
            if (bus.clr) begin nv = '0; np = 0; end
            if (m_done && !m_dirty) nv[m_dslot] = 1'b0;
            if (m_q.size() > 0) begin
                if (bus.drain_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) nd = 1;
                end
            end else if (!m_done && bus.drain_start) begin
                if (m_valid[bus.drain_slot]) begin
                    for (int l = 0; l < L; l++) m_q.push_back(m_mem[bus.drain_slot][l]);
                    m_dslot = int'(bus.drain_slot);
                    m_dirty = 0;
                end else begin
                    ne = 1;
                end
            end
            if (bus.we) begin
                if (bus.wr_auto) begin
                    if (!bus.clr && (&m_valid)) ne = 1;
                    else begin t = bus.clr ? 0 : m_ptr; wr = 1; np = (t + 1) % S; end
                end else begin
                    t = int'(bus.wr_slot); wr = 1;
                end
            end
            if (wr) begin
                for (int l = 0; l < L; l++) m_mem[t][l] = bus.wd[l*W +: W];
                nv[t] = 1'b1;
                if (t == m_dslot) m_dirty = 1;
            end
            m_valid = nv; m_ptr = np; m_err = ne; m_done = nd;
        end
        if (live) begin
            vectors++;
            for (int s = 0; s < S; s++)
                for (int l = 0; l < L; l++) exp_flat[(s*L+l)*W +: W] = m_mem[s][l];
            chk("rd_flat", bus.rd_flat, exp_flat);
            chk("slot_valid", bus.slot_valid, m_valid);
            chk("full", bus.full, &m_valid);
            chk("wr_err", bus.wr_err, m_err);
            chk("drain_valid", bus.drain_valid, m_q.size() > 0);
            chk("drain_busy", bus.drain_busy, (m_q.size() > 0) || m_done);
            chk("drain_done", bus.drain_done, m_done);
            if (m_q.size() > 0) chk("drain_data", bus.drain_data, m_q[0]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.we = 0; bus.wr_auto = 0; bus.wr_slot = '0; bus.wd = '0; bus.clr = 0;
        bus.drain_start = 0; bus.drain_slot = '0; bus.drain_ready = 0;
    endtask

    function automatic logic [L*W-1:0] vec(input int base);
        return {32'(base + 3), 32'(base + 2), 32'(base + 1), 32'(base)};
    endfunction

    logic [W-1:0] beats[$];
    int           pat [6] = '{1, 0, 1, 1, 0, 1};
    bit           seen;

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);

        // 1: reset then explicit write to slot 1
        tick();
        chk("t1_rst_valid", bus.slot_valid, 2'b00);
        chk("t1_rst_flat", bus.rd_flat, '0);
        chk("t1_rst_busy", bus.drain_busy, 1'b0);
        rst = 1'b0;
        bus.we = 1; bus.wr_slot = 1; bus.wd = vec(1);
        tick();
        idle_inputs();
        chk("t1_l0", bus.rd_flat[(1*L+0)*W +: W], 1);
        chk("t1_l3", bus.rd_flat[(1*L+3)*W +: W], 4);
        chk("t1_valid", bus.slot_valid, 2'b10);

        // 2: auto writes A, B, C with SLOTS=2
        rst = 1'b1; tick(); rst = 1'b0;
        bus.we = 1; bus.wr_auto = 1;
        bus.wd = vec(10); tick();
        bus.wd = vec(20); tick();
        chk("t2_full", bus.full, 1'b1);
        bus.wd = vec(30); tick();
        idle_inputs();
        chk("t2_err", bus.wr_err, 1'b1);
        chk("t2_s0", bus.rd_flat[0 +: W], 10);
        chk("t2_s1", bus.rd_flat[(1*L)*W +: W], 20);
        tick();
        chk("t2_err_pulse", bus.wr_err, 1'b0);

        // 3: drain slot 0 with a stalling ready pattern
        bus.drain_start = 1; bus.drain_slot = 0; tick();
        bus.drain_start = 0;
        beats.delete();
        for (int i = 0; i < 6; i++) begin
            bus.drain_ready = pat[i][0];
            if (pat[i] != 0 && bus.drain_valid) beats.push_back(bus.drain_data);
            tick();
        end
        bus.drain_ready = 0;
        chk("t3_done", bus.drain_done, 1'b1);
        chk("t3_nbeats", beats.size(), 4);
        for (int i = 0; i < 4 && i < beats.size(); i++) chk("t3_beat", beats[i], 10 + i);
        tick();
        chk("t3_done_pulse", bus.drain_done, 1'b0);
        chk("t3_valid", bus.slot_valid, 2'b10);

        // 4: drain slot 1, rewrite it during the second stream cycle
        bus.drain_start = 1; bus.drain_slot = 1; tick();
        bus.drain_start = 0;
        beats.delete();
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (bus.drain_done) seen = 1;
            else begin
                bus.drain_ready = 1;
                bus.we = (i == 1); bus.wr_slot = 1; bus.wd = vec(40);
                if (bus.drain_valid) beats.push_back(bus.drain_data);
                tick();
            end
        end
        idle_inputs();
        chk("t4_done_seen", seen, 1'b1);
        chk("t4_nbeats", beats.size(), 4);
        for (int i = 0; i < 4 && i < beats.size(); i++) chk("t4_beat", beats[i], 20 + i);
        tick();
        chk("t4_valid", bus.slot_valid, 2'b10);
        chk("t4_newdata", bus.rd_flat[(1*L)*W +: W], 40);

        // 5: clr with same-cycle auto write, then drain of an invalid slot
        bus.clr = 1; bus.we = 1; bus.wr_auto = 1; bus.wd = vec(50); tick();
        idle_inputs();
        chk("t5_valid", bus.slot_valid, 2'b01);
        bus.drain_start = 1; bus.drain_slot = 1; tick();
        idle_inputs();
        chk("t5_err", bus.wr_err, 1'b1);
        chk("t5_busy", bus.drain_busy, 1'b0);
        bus.we = 1; bus.wr_auto = 1; bus.wd = vec(60); tick();
        idle_inputs();
        chk("t5_ptr1", bus.rd_flat[(1*L)*W +: W], 60);
        chk("t5_valid2", bus.slot_valid, 2'b11);

        // 6: reset in the middle of a stream
        bus.drain_start = 1; bus.drain_slot = 0; tick();
        bus.drain_start = 0; bus.drain_ready = 1; tick(); tick();
        chk("t6_lane2", bus.drain_data, 52);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_valid", bus.drain_valid, 1'b0);
        chk("t6_busy", bus.drain_busy, 1'b0);
        chk("t6_sv", bus.slot_valid, 2'b00);
        chk("t6_flat", bus.rd_flat, '0);
        tick();
        chk("t6_after", bus.drain_valid, 1'b0);
        idle_inputs();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 199) == 0);
            bus.we          = ($urandom_range(0, 9) < 3);
            bus.wr_auto     = $urandom_range(0, 1);
            bus.wr_slot     = $urandom_range(0, S - 1);
            bus.wd          = {$urandom, $urandom, $urandom, $urandom};
            bus.clr         = ($urandom_range(0, 19) == 0);
            bus.drain_start = ($urandom_range(0, 4) == 0);
            bus.drain_slot  = $urandom_range(0, S - 1);
            bus.drain_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
